// File: rtl/meta_ingress_arb_pkg.sv
// Shared field widths and FSM encoding for the metadata ingress arbiter.
package meta_pkg;

    localparam int TUPLE_W = 104;
    localparam int SIZE_W  = 16;
    localparam int FLAG_W  = 8;
    localparam int WIND_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/meta_ingress_arb_rr_pick.sv
// Rotate-priority encoder: first set request at or above start_i, wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan farthest-first so the nearest set bit to start_i wins last.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(start_i) + k) % N]) begin
                idx_o   = IDX_W'((int'(start_i) + k) % N);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/meta_ingress_arb.sv
// Burst-limited weighted round-robin arbiter feeding parser headers into the metadata generator.
module meta_ingress_arb
    import meta_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req_v,
    output logic [NUM_PORTS-1:0]           req_rdy,
    input  logic [NUM_PORTS*TUPLE_W-1:0]   req_tuple,
    input  logic [NUM_PORTS*SIZE_W-1:0]    req_size,
    input  logic [NUM_PORTS*FLAG_W-1:0]    req_flag,
    input  logic [NUM_PORTS*WIND_W-1:0]    req_wind,
    input  logic                           ds_ready,
    input  logic                           cfg_en,
    output logic [TUPLE_W-1:0]             ip_tuple,
    output logic [SIZE_W-1:0]              pkt_size,
    output logic [FLAG_W-1:0]              pkt_flag,
    output logic [WIND_W-1:0]              wind_size,
    output logic                           pkt_v,
    output logic [$clog2(NUM_PORTS)-1:0]   src_port,
    output logic                           busy,
    output logic [CNT_W-1:0]               pkt_cnt,
    output logic [1:0]                     dbg_state
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   last_win_q, last_win_d;
    logic               last_vld_q, last_vld_d;
    logic [3:0]         burst_cnt_q, burst_cnt_d;

    logic               pkt_v_q;
    logic [TUPLE_W-1:0] tuple_q;
    logic [SIZE_W-1:0]  size_q;
    logic [FLAG_W-1:0]  flag_q;
    logic [WIND_W-1:0]  wind_q;
    logic [IDX_W-1:0]   src_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX_W-1:0]   rr_idx, win;
    logic               rr_found, sticky, grant, any_req;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        if (int'(i) >= NUM_PORTS - 1) return '0;
        return i + IDX_W'(1);
    endfunction

    rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
        .req_i   (req_v),
        .start_i (rr_ptr_q),
        .idx_o   (rr_idx),
        .found_o (rr_found)
    );

    // Handshake: a header moves when req_v[i] & req_rdy[i]; req_rdy is one-hot or zero
    // and depends only on registered state plus cfg_en/ds_ready/req_v of this cycle.
    always_comb begin
        any_req = |req_v;
        // last_vld_q keeps the reset value of last_win_q from being treated as history.
        sticky  = last_vld_q && req_v[last_win_q] && (burst_cnt_q < 4'(BURST_MAX));
        win     = sticky ? last_win_q : rr_idx;
        grant   = rst_n && (state_q == ST_SERVE) && cfg_en && ds_ready && (sticky || rr_found);
        req_rdy = grant ? (NUM_PORTS'(1) << win) : '0;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        last_win_d  = last_win_q;
        last_vld_d  = last_vld_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            ST_IDLE:  if (cfg_en && any_req) state_d = ST_SERVE;
            ST_SERVE: begin
                if (!cfg_en)                 state_d = ST_PAUSE;
                else if (!any_req && !grant) state_d = ST_IDLE;
            end
            ST_PAUSE: if (cfg_en) state_d = any_req ? ST_SERVE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (grant) begin
            last_win_d = win;
            last_vld_d = 1'b1;
            // An exhausted burst restarts at 1 even when the same port wins the rescan.
            if (last_vld_q && (win == last_win_q) && (burst_cnt_q < 4'(BURST_MAX)))
                burst_cnt_d = burst_cnt_q + 4'd1;
            else
                burst_cnt_d = 4'd1;
            if (!sticky || (burst_cnt_d == 4'(BURST_MAX)))
                rr_ptr_d = inc_idx(win);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            last_win_q  <= '0;
            last_vld_q  <= 1'b0;
            burst_cnt_q <= '0;
            pkt_v_q     <= 1'b0;
            tuple_q     <= '0;
            size_q      <= '0;
            flag_q      <= '0;
            wind_q      <= '0;
            src_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            last_win_q  <= last_win_d;
            last_vld_q  <= last_vld_d;
            burst_cnt_q <= burst_cnt_d;
            pkt_v_q     <= grant;
            if (grant) begin
                tuple_q <= req_tuple[win*TUPLE_W +: TUPLE_W];
                size_q  <= req_size[win*SIZE_W +: SIZE_W];
                flag_q  <= req_flag[win*FLAG_W +: FLAG_W];
                wind_q  <= req_wind[win*WIND_W +: WIND_W];
                src_q   <= win;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ip_tuple  = tuple_q;
    assign pkt_size  = size_q;
    assign pkt_flag  = flag_q;
    assign wind_size = wind_q;
    assign pkt_v     = pkt_v_q;
    assign src_port  = src_q;
    assign pkt_cnt   = cnt_q;
    assign busy      = (state_q == ST_SERVE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_meta_ingress_arb.sv
// Directed bench for meta_ingress_arb: predicted grant order feeds an expected queue checked at pkt_v.
module tb_meta_ingress_arb;
  import meta_pkg::*;

  localparam int NP    = 4;
  localparam int EXP_W = 2 + TUPLE_W + SIZE_W + FLAG_W + WIND_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NP-1:0]           req_v;
  logic [NP-1:0]           req_rdy;
  logic [NP*TUPLE_W-1:0]   req_tuple;
  logic [NP*SIZE_W-1:0]    req_size;
  logic [NP*FLAG_W-1:0]    req_flag;
  logic [NP*WIND_W-1:0]    req_wind;
  logic                    ds_ready;
  logic                    cfg_en;
  logic [TUPLE_W-1:0]      ip_tuple;
  logic [SIZE_W-1:0]       pkt_size;
  logic [FLAG_W-1:0]       pkt_flag;
  logic [WIND_W-1:0]       wind_size;
  logic                    pkt_v;
  logic [1:0]              src_port;
  logic                    busy;
  logic [3:0]              pkt_cnt;
  logic [1:0]              dbg_state;

  logic [EXP_W-1:0]   exp_q[$];
  int                 n_checks = 0;
  int                 n_errors = 0;
  logic [3:0]         exp_cnt;
  logic [TUPLE_W-1:0] last_tuple;

  meta_ingress_arb #(.NUM_PORTS(NP), .BURST_MAX(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_v     (req_v),
    .req_rdy   (req_rdy),
    .req_tuple (req_tuple),
    .req_size  (req_size),
    .req_flag  (req_flag),
    .req_wind  (req_wind),
    .ds_ready  (ds_ready),
    .cfg_en    (cfg_en),
    .ip_tuple  (ip_tuple),
    .pkt_size  (pkt_size),
    .pkt_flag  (pkt_flag),
    .wind_size (wind_size),
    .pkt_v     (pkt_v),
    .src_port  (src_port),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_fields(input int p);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    req_tuple[p*TUPLE_W +: TUPLE_W] = r[TUPLE_W-1:0];
    req_size[p*SIZE_W +: SIZE_W]    = 16'($urandom_range(64, 1500));
    req_flag[p*FLAG_W +: FLAG_W]    = 8'($urandom_range(0, 255));
    req_wind[p*WIND_W +: WIND_W]    = 16'($urandom_range(0, 65535));
  endtask

  // One clock: exp_port is the port the arbiter must accept this cycle, -1 for none.
  task automatic step(input int exp_port);
    logic [EXP_W-1:0] e;
    logic [NP-1:0]    exp_rdy;
    @(negedge clk);
    exp_rdy = (exp_port >= 0) ? NP'(1 << exp_port) : '0;
    check("req_rdy", 128'(req_rdy), 128'(exp_rdy));
    if (exp_port >= 0) begin
      exp_q.push_back({2'(exp_port),
                       req_tuple[exp_port*TUPLE_W +: TUPLE_W],
                       req_size[exp_port*SIZE_W +: SIZE_W],
                       req_flag[exp_port*FLAG_W +: FLAG_W],
                       req_wind[exp_port*WIND_W +: WIND_W]});
      exp_cnt = (exp_cnt == 4'hf) ? 4'hf : exp_cnt + 4'd1;
    end
    @(posedge clk);
    #1;
    check("pkt_v", 128'(pkt_v), 128'(exp_port >= 0));
    if (pkt_v === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("src_port",  128'(src_port),  128'(e[EXP_W-1 -: 2]));
        check("ip_tuple",  128'(ip_tuple),  128'(e[EXP_W-3 -: TUPLE_W]));
        check("pkt_size",  128'(pkt_size),  128'(e[SIZE_W+FLAG_W+WIND_W-1 -: SIZE_W]));
        check("pkt_flag",  128'(pkt_flag),  128'(e[FLAG_W+WIND_W-1 -: FLAG_W]));
        check("wind_size", 128'(wind_size), 128'(e[WIND_W-1:0]));
        last_tuple = e[EXP_W-3 -: TUPLE_W];
      end
    end else begin
      check("ip_tuple_hold", 128'(ip_tuple), 128'(last_tuple));
    end
    check("pkt_cnt", 128'(pkt_cnt), 128'(exp_cnt));
    if (exp_port >= 0) new_fields(exp_port);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pkt_v",   128'(pkt_v),     128'(0));
    check("rst_pkt_cnt", 128'(pkt_cnt),   128'(0));
    check("rst_src",     128'(src_port),  128'(0));
    check("rst_tuple",   128'(ip_tuple),  128'(0));
    check("rst_state",   128'(dbg_state), 128'(ST_IDLE));
    check("rst_req_rdy", 128'(req_rdy),   128'(0));
    exp_cnt    = '0;
    last_tuple = '0;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req_v    = '0;
    ds_ready = 1'b0;
    cfg_en   = 1'b0;
    for (int p = 0; p < NP; p++) new_fields(p);
    do_reset();

    // Ports 0 and 2 contend: bursts of four, then rotation.
    cfg_en = 1'b1; ds_ready = 1'b1; req_v = 4'b0101;
    step(-1);
    check("busy_serve", 128'(busy), 128'(1));
    for (int i = 0; i < 4; i++) step(0);
    for (int i = 0; i < 4; i++) step(2);
    check("cnt_after_8", 128'(pkt_cnt), 128'(8));
    step(0);
    req_v = '0;
    step(-1);
    check("idle_after_drain", 128'(dbg_state), 128'(ST_IDLE));

    // All four valid, each drops after its accept.
    req_v = 4'b1111;
    step(-1);
    for (int p = 0; p < NP; p++) begin
      step(p);
      req_v[p] = 1'b0;
    end
    step(-1);

    // ds_ready stall with port 0 at burst 2.
    req_v = 4'b0011;
    step(-1);
    step(0);
    step(0);
    ds_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(-1);
    check("stall_busy", 128'(busy), 128'(1));
    ds_ready = 1'b1;
    step(0);
    step(0);
    step(1);

    // Pause with requests pending; rr_ptr (now 2) must survive the pause.
    cfg_en = 1'b0;
    step(-1);
    check("pause_state", 128'(dbg_state), 128'(ST_PAUSE));
    check("pause_busy",  128'(busy),      128'(0));
    req_v = 4'b1101;
    step(-1);
    step(-1);
    cfg_en = 1'b1;
    step(-1);
    check("resume_state", 128'(dbg_state), 128'(ST_SERVE));
    step(2);
    req_v = 4'b1001;
    step(3);

    // Reset lands on the edge where port 1 is accepted.
    req_v = 4'b0010;
    @(negedge clk);
    check("rdy_before_rst", 128'(req_rdy), 128'(4'b0010));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_pkt_v", 128'(pkt_v),     128'(0));
    check("midrst_cnt",   128'(pkt_cnt),   128'(0));
    check("midrst_state", 128'(dbg_state), 128'(ST_IDLE));
    exp_cnt    = '0;
    last_tuple = '0;
    rst_n = 1'b1;

    // Single requester: every cycle granted, counter saturates at 15.
    req_v = 4'b0001;
    step(-1);
    for (int i = 0; i < 14; i++) step(0);
    check("cnt_14", 128'(pkt_cnt), 128'(14));
    for (int i = 0; i < 3; i++) step(0);
    check("cnt_sat", 128'(pkt_cnt), 128'(15));
    req_v = '0;
    step(-1);
    step(-1);
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/meta_ingress_arb.md
Name: meta_ingress_arb

Overview:
- Shares the single metadata-generator datapath among NUM_PORTS packet-header parsers.
- Each parser presents a 5-tuple, packet size, TCP flags and window size with a valid/ready handshake.
- The block picks one header per cycle by weighted round-robin (burst-limited) and drives a registered, one-cycle pkt_v strobe plus fields into the metadata generator.
- Provides enable/pause control and a packet counter for the control plane.

Parameters:
- NUM_PORTS, 4, number of requesting parser ports (2..8).
- BURST_MAX, 4, maximum consecutive grants to one port while others are waiting (1..15).
- CNT_W, 32, width of the forwarded-packet counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- req_v  in  NUM_PORTS  per-port header valid.
- req_rdy  out  NUM_PORTS  per-port accept. A transfer occurs when req_v[i] & req_rdy[i].
- req_tuple  in  NUM_PORTS*104  per-port 5-tuple. Port i occupies [i*104 +: 104].
- req_size  in  NUM_PORTS*16  per-port packet size.
- req_flag  in  NUM_PORTS*8  per-port TCP flags.
- req_wind  in  NUM_PORTS*16  per-port window size.
- ds_ready  in  1  the metadata generator / downstream can take a header this cycle.
- cfg_en  in  1  arbitration enable.
- ip_tuple  out  104  to generator.
- pkt_size  out  16  to generator.
- pkt_flag  out  8  to generator.
- wind_size  out  16  to generator.
- pkt_v  out  1  one-cycle strobe qualifying the four outputs above.
- src_port  out  clog2(NUM_PORTS)  index of the port that supplied the current pkt_v.
- busy  out  1  high while state is SERVE.
- pkt_cnt  out  CNT_W  count of forwarded headers; saturates at all-ones.

Behaviour:
- Reset is synchronous. While rst_n is low at a clk edge, all of the following clear to 0: pkt_v, ip_tuple, pkt_size, pkt_flag, wind_size, src_port, pkt_cnt, rr_ptr, burst_cnt, last_win. State goes to IDLE. req_rdy is 0 during reset.
- Reset mid-transfer discards the in-flight header. There is no partial output.
- States:
  - IDLE: no grant.
    - To SERVE when cfg_en=1 and any req_v=1.
  - SERVE: grants allowed.
    - To PAUSE when cfg_en=0.
    - To IDLE when no req_v is high and no grant is made this cycle.
  - PAUSE: no grant. burst_cnt and rr_ptr are held.
    - To SERVE when cfg_en=1 and any req_v=1.
    - To IDLE when cfg_en=1 and all req_v=0.
- Grant rule (combinational, evaluated only in SERVE with ds_ready=1):
  - If req_v[last_win]=1, burst_cnt<BURST_MAX and last_win is valid history, the winner is last_win.
  - Otherwise the winner is the first set req_v scanning from rr_ptr upward, modulo NUM_PORTS.
  - req_rdy = one-hot(winner) when a grant is made, else 0. req_rdy never has more than one bit set.
- On a grant:
  - Next edge registers the winner's fields onto the outputs and sets pkt_v=1 and src_port=winner. Latency is 1 cycle from the accepted handshake.
  - pkt_cnt increments by 1 unless it is all-ones.
  - If winner==last_win, burst_cnt increments; else burst_cnt=1 and last_win=winner.
  - When the winner was chosen by RR scan, rr_ptr=winner+1 (mod NUM_PORTS).
  - When burst_cnt reaches BURST_MAX, rr_ptr=last_win+1.
- With no grant, pkt_v=0 and data outputs hold their last value.
- ds_ready=0: no grant. burst_cnt and rr_ptr are unchanged. A requester holding req_v is not penalised.
- Requesters must hold their fields stable while req_v=1 and not accepted. The block does not check this.
- Single requester: it is granted every cycle. burst_cnt wraps to 1 after BURST_MAX and the same port wins again. Back-to-back throughput is 1 header/cycle.
- cfg_en falling in the same cycle as a pending grant: no grant that cycle. cfg_en is sampled combinationally with state.
- pkt_cnt saturates and does not wrap.

Decomposition:
- Shared package meta_pkg holds:
  - TUPLE_W=104, SIZE_W=16, FLAG_W=8, WIND_W=16.
  - State encoding ST_IDLE/ST_SERVE/ST_PAUSE (2-bit).
- One natural sub-module: rr_pick. It is a combinational rotate-priority encoder with inputs (req vector, start pointer) and outputs (winner index, found flag). It is reusable by other shared datapaths.

Test Plan:
- Reset, then ports 0 and 2 both valid continuously with ds_ready=1, BURST_MAX=4 -> src_port sequence 0,0,0,0,2,2,2,2,0… ; pkt_v high every cycle from cycle 1; pkt_cnt=8 after 8 grants.
- All 4 ports valid, each dropping req_v after one accept -> grants 0,1,2,3 in consecutive cycles; fields on ip_tuple match each port's tuple exactly one cycle after its req_rdy.
- ds_ready low for 3 cycles mid-burst at burst_cnt=2 -> req_rdy=0 and pkt_v=0 for 3 cycles; resumes with the same port for 2 more grants before rotation.
- cfg_en deasserted with ports valid -> PAUSE, busy=0, no req_rdy. Re-enable -> SERVE, arbitration resumes from the held rr_ptr.
- Preload pkt_cnt near saturation (CNT_W=4, 14 grants, then 3 more) -> pkt_cnt reads 15 and stays 15.
- Assert rst_n=0 for one edge while port 1 is being granted -> next cycle pkt_v=0, pkt_cnt=0, state IDLE; the header is not forwarded.
